// File: rtl/time_display_mux.sv
// Converts binary hh:mm:ss to BCD with a subtract-by-ten FSM and scans six multiplexed 7-segment digits; COLON_BLINK_EN adds colon blink on dp.
// Latency: change-to-commit is 1 + (tensH+1) + (tensM+1) + (tensS+1) + 1 cycles; seg/digit_en lag the scan index by one cycle.
// Backpressure: none; input changes during a conversion are picked up once the FSM returns to IDLE.
module time_display_mux #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] digit_en,
    output logic       conv_busy,
    output logic       update_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CONV_H,
        CONV_M,
        CONV_S,
        COMMIT
    } state_t;

    state_t state, state_nxt;

    logic [17:0] snap;
    logic [5:0]  work;
    logic [3:0]  tens;
    logic [3:0]  h_ones, h_tens, m_ones, m_tens, s_ones, s_tens;
    logic [23:0] disp;
    logic [15:0] prescale;
    logic [2:0]  idx;
    logic [3:0]  cur_bcd;
    logic        step_sub;

    assign step_sub = (work >= 6'd10);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        conv_busy   = 1'b1;
        update_done = 1'b0;
        case (state)
            IDLE: begin
                conv_busy = 1'b0;
                if ({hours, minutes, seconds} != snap) state_nxt = LOAD;
            end
            LOAD:   state_nxt = CONV_H;
            CONV_H: if (!step_sub) state_nxt = CONV_M;
            CONV_M: if (!step_sub) state_nxt = CONV_S;
            CONV_S: if (!step_sub) state_nxt = COMMIT;
            COMMIT: begin
                update_done = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One working register is reused for all three fields; the next field is
    // reloaded from the snapshot so late input changes cannot leak in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap   <= '0;
            work   <= '0;
            tens   <= '0;
            h_ones <= '0;
            h_tens <= '0;
            m_ones <= '0;
            m_tens <= '0;
            s_ones <= '0;
            s_tens <= '0;
            disp   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    snap <= {hours, minutes, seconds};
                    work <= hours;
                    tens <= '0;
                end
                CONV_H: begin
                    if (step_sub) begin
                        work <= work - 6'd10;
                        tens <= tens + 4'd1;
                    end else begin
                        h_ones <= work[3:0];
                        h_tens <= tens;
                        work   <= snap[11:6];
                        tens   <= '0;
                    end
                end
                CONV_M: begin
                    if (step_sub) begin
                        work <= work - 6'd10;
                        tens <= tens + 4'd1;
                    end else begin
                        m_ones <= work[3:0];
                        m_tens <= tens;
                        work   <= snap[5:0];
                        tens   <= '0;
                    end
                end
                CONV_S: begin
                    if (step_sub) begin
                        work <= work - 6'd10;
                        tens <= tens + 4'd1;
                    end else begin
                        s_ones <= work[3:0];
                        s_tens <= tens;
                    end
                end
                COMMIT: disp <= {h_tens, h_ones, m_tens, m_ones, s_tens, s_ones};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale <= '0;
            idx      <= '0;
        end else if (prescale == 16'(SCAN_DIV - 1)) begin
            prescale <= '0;
            idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            prescale <= prescale + 16'd1;
        end
    end

    always_comb begin
        cur_bcd = disp[3:0];
        case (idx)
            3'd0:    cur_bcd = disp[3:0];
            3'd1:    cur_bcd = disp[7:4];
            3'd2:    cur_bcd = disp[11:8];
            3'd3:    cur_bcd = disp[15:12];
            3'd4:    cur_bcd = disp[19:16];
            3'd5:    cur_bcd = disp[23:20];
            default: cur_bcd = disp[3:0];
        endcase
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        p = 7'h00;
        case (d)
            4'd0: p = 7'h3F;
            4'd1: p = 7'h06;
            4'd2: p = 7'h5B;
            4'd3: p = 7'h4F;
            4'd4: p = 7'h66;
            4'd5: p = 7'h6D;
            4'd6: p = 7'h7D;
            4'd7: p = 7'h07;
            4'd8: p = 7'h7F;
            4'd9: p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg      <= '0;
            digit_en <= '0;
        end else begin
            seg      <= seg_decode(cur_bcd);
            digit_en <= 6'b000001 << idx;
        end
    end

`ifdef COLON_BLINK_EN
    // Colon segments sit on digits 2 and 4; they blink at the 1 Hz seconds rate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dp <= 1'b0;
        else          dp <= ((idx == 3'd2) || (idx == 3'd4)) && disp[0];
    end
`else
    assign dp = 1'b0;
`endif

endmodule

// File: doc/time_display_mux.md
TIME_DISPLAY_MUX -- requirements
Module: time_display_mux

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles each digit is driven (range 2..65535).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port hours  input  6  binary hours from the clock counter.
REQ-005 SHALL have port minutes  input  6  binary minutes.
REQ-006 SHALL have port seconds  input  6  binary seconds.
REQ-007 SHALL have port seg  output  7  segment pattern, active-high, bit0=a ... bit6=g.
REQ-008 SHALL have port dp  output  1  decimal point, active-high.
REQ-009 SHALL have port digit_en  output  6  one-hot digit select, active-high.
REQ-010 SHALL have port conv_busy  output  1  high while a binary-to-BCD conversion is in progress.
REQ-011 SHALL have port update_done  output  1  one-cycle pulse when new BCD digits are committed.

Function
REQ-012 SHALL hold a 18-bit snapshot of {hours,minutes,seconds}; in IDLE, if inputs != snapshot, SHALL go to LOAD next cycle.
REQ-013 FSM states SHALL be IDLE, LOAD, CONV_H, CONV_M, CONV_S, COMMIT; LOAD copies inputs to snapshot and working regs, then CONV_H.
REQ-014 Each CONV state SHALL do one step per cycle: if work >= 10, subtract 10 and increment tens; else store ones=work and advance (CONV_H->CONV_M->CONV_S->COMMIT).
REQ-015 COMMIT SHALL write all six BCD digits to the display register in one cycle, pulse update_done, return to IDLE.
REQ-016 Latency change-to-commit SHALL be 1 + (tensH+1) + (tensM+1) + (tensS+1) + 1 cycles; 23:59:59 = 17 cycles.
REQ-017 Input values >= 60 SHALL convert without clamping (63 -> tens 6, ones 3).
REQ-018 Input changes during LOAD..COMMIT SHALL not affect the conversion in progress; they are detected in IDLE the cycle after COMMIT.
REQ-019 conv_busy SHALL be high in LOAD through COMMIT inclusive, low in IDLE.
REQ-020 Prescaler SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and digit index advances 0..5, wrapping 5->0.
REQ-021 Digit map SHALL be: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hr ones, 5 hr tens.
REQ-022 seg and digit_en SHALL be registered, updating together one cycle after the index changes; digit_en = 1<<index.
REQ-023 Decoder SHALL emit standard patterns for 0-9 (0=0x3F, 1=0x06, 8=0x7F); BCD 10-15 SHALL emit 0x00.
REQ-024 A commit coinciding with an index advance SHALL display the newly committed digit value.

Reset
REQ-025 On reset_n low: seg=0, dp=0, digit_en=0, conv_busy=0, update_done=0, FSM=IDLE, prescaler=0, index=0, snapshot=0, all BCD digits=0.
REQ-026 First cycle after reset_n rises: digit_en=6'b000001, seg=0x3F.
REQ-027 reset_n asserted mid-conversion SHALL abort it; the display register SHALL hold zeros, no update_done.
REQ-028 After release, nonzero inputs SHALL trigger a conversion via REQ-012.

Configuration
REQ-029 Macro COLON_BLINK_EN: when defined, dp SHALL equal bit0 of committed seconds-ones digit while index is 2 or 4, else 0.
REQ-030 Without COLON_BLINK_EN, dp SHALL be constant 0 and no blink logic synthesized.

Verification
REQ-031 Reset, inputs 0, SCAN_DIV=4 -> digit_en cycles 000001..100000 every 4 cycles, seg=0x3F throughout, no update_done.
REQ-032 Inputs 23:59:59 from 0 -> conv_busy high 17 cycles, update_done once, digits 9,5,9,5,3,2 (seg 0x6F,0x6D,0x6F,0x6D,0x4F,0x5B).
REQ-033 Change seconds 10->11 at cycle 3 of conversion -> first commit shows 10, second conversion starts next IDLE cycle, commits 11.
REQ-034 Input seconds=63 -> digit1=6 (0x7D), digit0=3 (0x4F).
REQ-035 reset_n low during CONV_M -> outputs per REQ-025 immediately; after release conversion restarts and completes.
REQ-036 COLON_BLINK_EN defined, seconds=7 -> dp=1 only while digit_en is 000100 or 010000; seconds=8 -> dp=0 always.
